// File: rtl/instr_decode_ctrl_if.sv
// Fetch handshake plus register-file/ALU control bundle for instr_decode_ctrl.
// The slave modport is the decode block; the master modport is the fetch/regfile side.
interface instr_decode_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             instr_vld;
  logic [31:0]      instr_dat;
  logic             instr_rdy;
  logic [2:0]       rd_reg1;
  logic [2:0]       rd_reg2;
  logic [2:0]       wr_reg;
  logic             wr_en;
  logic [7:0]       imm_dat;
  logic             imm_sel;
  logic             neg_sel;
  logic [2:0]       alu_op;
  logic             busy;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    output instr_vld, instr_dat,
    input  instr_rdy, rd_reg1, rd_reg2, wr_reg, wr_en, imm_dat,
           imm_sel, neg_sel, alu_op, busy, illegal, retired
  );

  modport slave (
    input  instr_vld, instr_dat,
    output instr_rdy, rd_reg1, rd_reg2, wr_reg, wr_en, imm_dat,
           imm_sel, neg_sel, alu_op, busy, illegal, retired
  );
endinterface

// File: rtl/instr_decode_ctrl.sv
// Decode/sequencing stage ahead of the 8x8 register file: one instruction every 2+EXEC_CYCLES cycles,
// single-cycle write strobe in WB; instr_rdy only in IDLE/WB, upstream holds the word otherwise.
module instr_decode_ctrl #(
  parameter int EXEC_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  instr_decode_ctrl_if.slave dec_if
);

  if (EXEC_CYCLES < 1) begin : g_bad_exec_cycles
    $error("instr_decode_ctrl: EXEC_CYCLES must be >= 1");
  end

  localparam int CNT_EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_EW-1:0] r_cnt;
  logic [CNT_EW-1:0] w_cnt_nxt;
  logic              r_legal;
  logic              r_wr_en;
  logic              r_illegal;
  logic [2:0]        r_rd1;
  logic [2:0]        r_rd2;
  logic [2:0]        r_wr;
  logic [7:0]        r_imm;
  logic              r_imm_sel;
  logic              r_neg_sel;
  logic [2:0]        r_alu_op;
  logic [CNT_W-1:0]  r_retired;

  logic              w_rdy;
  logic              w_accept;
  logic [7:0]        w_op;
  logic              w_legal;
  logic              w_imm_sel;
  logic              w_neg_sel;
  logic [2:0]        w_alu_op;
  logic              w_unused;

  // Ready is gated by reset so it reads 0 throughout reset and 1 in the first cycle after release.
  assign w_rdy    = i_rst_n && ((r_state == S_IDLE) || (r_state == S_WB));
  assign w_accept = dec_if.instr_vld && w_rdy;

  assign w_op     = dec_if.instr_dat[31:24];
  assign w_legal  = (w_op <= 8'd5);
  assign w_unused = &{1'b0, dec_if.instr_dat[23:19], dec_if.instr_dat[15:11]};

  always_comb begin
    w_imm_sel = 1'b0;
    w_neg_sel = 1'b0;
    w_alu_op  = ALU_FWD;
    case (w_op)
      8'd0: w_imm_sel = 1'b1;
      8'd2: w_alu_op  = ALU_ADD;
      8'd3: begin
        w_alu_op  = ALU_ADD;
        w_neg_sel = 1'b1;
      end
      8'd4: w_alu_op  = ALU_AND;
      8'd5: w_alu_op  = ALU_OR;
      default: w_alu_op = ALU_FWD;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (r_legal) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = CNT_EW'(EXEC_CYCLES - 1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) w_state_nxt = S_WB;
        else             w_cnt_nxt   = r_cnt - CNT_EW'(1);
      end
      S_WB: begin
        w_state_nxt = w_accept ? S_DECODE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Decode is registered at the accept edge, so outputs are valid from DECODE and hold through WB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_legal   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_illegal <= 1'b0;
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_wr      <= '0;
      r_imm     <= '0;
      r_imm_sel <= 1'b0;
      r_neg_sel <= 1'b0;
      r_alu_op  <= ALU_FWD;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr_en   <= (w_state_nxt == S_WB);
      r_illegal <= w_accept && !w_legal;
      if (w_accept) begin
        r_legal   <= w_legal;
        r_rd1     <= dec_if.instr_dat[10:8];
        r_rd2     <= dec_if.instr_dat[2:0];
        r_wr      <= dec_if.instr_dat[18:16];
        r_imm     <= dec_if.instr_dat[7:0];
        r_imm_sel <= w_imm_sel;
        r_neg_sel <= w_neg_sel;
        r_alu_op  <= w_alu_op;
      end
      if (r_state == S_WB) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign dec_if.instr_rdy = w_rdy;
  assign dec_if.rd_reg1   = r_rd1;
  assign dec_if.rd_reg2   = r_rd2;
  assign dec_if.wr_reg    = r_wr;
  assign dec_if.wr_en     = r_wr_en;
  assign dec_if.imm_dat   = r_imm;
  assign dec_if.imm_sel   = r_imm_sel;
  assign dec_if.neg_sel   = r_neg_sel;
  assign dec_if.alu_op    = r_alu_op;
  assign dec_if.busy      = (r_state != S_IDLE);
  assign dec_if.illegal   = r_illegal;
  assign dec_if.retired   = r_retired;

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Self-checking bench: directed spec scenarios plus random traffic against a timeline model.
module tb_instr_decode_ctrl;
  localparam int E1 = 2;
  localparam int E2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n;
  logic rst2_n;

  instr_decode_ctrl_if #(.CNT_W(16)) b1 ();
  instr_decode_ctrl_if #(.CNT_W(2))  b2 ();

  instr_decode_ctrl #(.EXEC_CYCLES(E1), .CNT_W(16)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst1_n), .dec_if(b1)
  );
  instr_decode_ctrl #(.EXEC_CYCLES(E2), .CNT_W(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst2_n), .dec_if(b2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: an instruction occupies 2+E cycles if legal (write in the last), 1 cycle if illegal.
  bit          m_act;
  bit          m_legal;
  logic [31:0] m_word;
  int          m_age;
  logic [15:0] m_ret;
  int          cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_rdy();
    return !m_act || (m_legal && m_age == 2 + E1);
  endfunction

  function automatic logic [2:0] exp_alu(input logic [7:0] op);
    case (op)
      8'd2, 8'd3: return 3'b001;
      8'd4:       return 3'b010;
      8'd5:       return 3'b011;
      default:    return 3'b000;
    endcase
  endfunction

  task automatic check1();
    chk("ready",   b1.instr_rdy, m_rdy());
    chk("busy",    b1.busy, m_act);
    chk("we",      b1.wr_en, m_act && m_legal && m_age == 2 + E1);
    chk("illegal", b1.illegal, m_act && !m_legal && m_age == 1);
    chk("retired", b1.retired, m_ret);
    if (m_act) begin
      chk("rd1", b1.rd_reg1, m_word[10:8]);
      chk("rd2", b1.rd_reg2, m_word[2:0]);
      chk("wr",  b1.wr_reg, m_word[18:16]);
      chk("imm", b1.imm_dat, m_word[7:0]);
      if (m_legal) begin
        chk("alu",     b1.alu_op, exp_alu(m_word[31:24]));
        chk("imm_sel", b1.imm_sel, m_word[31:24] == 8'd0);
        chk("neg_sel", b1.neg_sel, m_word[31:24] == 8'd3);
      end
    end
  endtask

  task automatic step1();
    bit rdy;
    bit done;
    rdy  = m_rdy();
    done = m_act && (m_legal ? (m_age == 2 + E1) : (m_age == 1));
    @(posedge clk);
    cyc++;
    if (done && m_legal) m_ret++;
    if (rdy && b1.instr_vld) begin
      m_act   = 1'b1;
      m_word  = b1.instr_dat;
      m_age   = 1;
      m_legal = (b1.instr_dat[31:24] <= 8'd5);
    end else if (done) begin
      m_act = 1'b0;
    end else if (m_act) begin
      m_age++;
    end
    @(negedge clk);
    check1();
  endtask

  task automatic step2();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issues one add on dut2 from IDLE and walks it to the cycle after WB.
  task automatic retire2(input string tag);
    b2.instr_vld = 1'b1;
    b2.instr_dat = 32'h02010203;
    step2();
    b2.instr_vld = 1'b0;
    repeat (2 + E2 - 1) step2();
    chk({tag, "_we"}, b2.wr_en, 1'b1);
    step2();
    chk({tag, "_we_off"}, b2.wr_en, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          we_cnt;
    int          idx;
    int          acc[$];
    bit          rdy_obs;
    logic [15:0] ret0;
    logic [31:0] b2b[3];
    b2b[0] = 32'h02010203;
    b2b[1] = 32'h04020304;
    b2b[2] = 32'h05030506;

    m_act = 1'b0; m_legal = 1'b0; m_word = '0; m_age = 0; m_ret = '0; cyc = 0;
    rst1_n = 1'b0; rst2_n = 1'b0;
    b1.instr_vld = 1'b0; b1.instr_dat = '0;
    b2.instr_vld = 1'b0; b2.instr_dat = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ready",   b1.instr_rdy, 1'b0);
    chk("rst_we",      b1.wr_en, 1'b0);
    chk("rst_busy",    b1.busy, 1'b0);
    chk("rst_illegal", b1.illegal, 1'b0);
    chk("rst_retired", b1.retired, 16'd0);
    chk("rst_rd1",     b1.rd_reg1, 3'd0);
    chk("rst_wr",      b1.wr_reg, 3'd0);
    chk("rst_imm",     b1.imm_dat, 8'd0);
    chk("rst_alu",     b1.alu_op, 3'd0);
    chk("rst2_ready",  b2.instr_rdy, 1'b0);
    rst1_n = 1'b1; rst2_n = 1'b1;
    #1;
    chk("rel_ready",  b1.instr_rdy, 1'b1);
    chk("rel2_ready", b2.instr_rdy, 1'b1);

    // add, valid held while busy
    b1.instr_vld = 1'b1; b1.instr_dat = 32'h02030102;
    step1();
    chk("add_rd1", b1.rd_reg1, 3'd1);
    chk("add_rd2", b1.rd_reg2, 3'd2);
    chk("add_wr",  b1.wr_reg, 3'd3);
    chk("add_alu", b1.alu_op, 3'b001);
    step1(); chk("add_we_c2", b1.wr_en, 1'b0);
    step1(); chk("add_we_c3", b1.wr_en, 1'b0);
    step1(); chk("add_we_c4", b1.wr_en, 1'b1);
    b1.instr_vld = 1'b0;
    step1(); chk("add_we_c5", b1.wr_en, 1'b0);
    chk("add_retired", b1.retired, 16'd1);

    // loadi
    b1.instr_vld = 1'b1; b1.instr_dat = 32'h0005004D;
    step1();
    b1.instr_vld = 1'b0;
    chk("ldi_imm_sel", b1.imm_sel, 1'b1);
    chk("ldi_imm",     b1.imm_dat, 8'h4D);
    chk("ldi_wr",      b1.wr_reg, 3'd5);
    chk("ldi_alu",     b1.alu_op, 3'b000);
    we_cnt = 0;
    repeat (4) begin step1(); we_cnt += int'(b1.wr_en); end
    chk("ldi_we_count", we_cnt, 1);

    // sub
    b1.instr_vld = 1'b1; b1.instr_dat = 32'h03070406;
    step1();
    b1.instr_vld = 1'b0;
    chk("sub_neg", b1.neg_sel, 1'b1);
    chk("sub_alu", b1.alu_op, 3'b001);
    chk("sub_rd1", b1.rd_reg1, 3'd4);
    chk("sub_rd2", b1.rd_reg2, 3'd6);
    chk("sub_wr",  b1.wr_reg, 3'd7);
    repeat (4) step1();
    chk("sub_retired", b1.retired, 16'd3);

    // illegal opcode
    b1.instr_vld = 1'b1; b1.instr_dat = 32'h09123456;
    step1();
    b1.instr_vld = 1'b0;
    chk("ill_pulse", b1.illegal, 1'b1);
    chk("ill_we",    b1.wr_en, 1'b0);
    chk("ill_ready", b1.instr_rdy, 1'b0);
    step1();
    chk("ill_pulse_off", b1.illegal, 1'b0);
    chk("ill_ready_back", b1.instr_rdy, 1'b1);
    chk("ill_retired", b1.retired, 16'd3);

    // three back-to-back instructions, valid held; accepts observed from the DUT's ready
    ret0 = b1.retired;
    idx  = 0;
    b1.instr_vld = 1'b1; b1.instr_dat = b2b[0];
    for (int i = 0; i < 30 && idx < 3; i++) begin
      rdy_obs = b1.instr_rdy;
      step1();
      if (rdy_obs) begin
        acc.push_back(cyc);
        idx++;
        if (idx < 3) b1.instr_dat = b2b[idx];
        else         b1.instr_vld = 1'b0;
      end
    end
    repeat (2 + E1) step1();
    chk("b2b_accepts", idx, 3);
    if (acc.size() == 3) begin
      chk("b2b_period1", acc[1] - acc[0], 2 + E1);
      chk("b2b_period2", acc[2] - acc[1], 2 + E1);
    end
    chk("b2b_retired", b1.retired - ret0, 16'd3);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      b1.instr_vld = ($urandom_range(0, 9) < 7);
      b1.instr_dat[23:0]  = 24'($urandom);
      b1.instr_dat[31:24] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      step1();
    end
    b1.instr_vld = 1'b0;
    repeat (2 + E1) step1();

    // dut2: 2-bit retire counter wraps after 4 retires
    retire2("wrap1"); chk("wrap_ret1", b2.retired, 2'd1);
    retire2("wrap2"); chk("wrap_ret2", b2.retired, 2'd2);
    retire2("wrap3"); chk("wrap_ret3", b2.retired, 2'd3);
    retire2("wrap4"); chk("wrap_ret0", b2.retired, 2'd0);

    // dut2: preload to 3, then reset in the middle of EXEC
    retire2("pre1"); retire2("pre2"); retire2("pre3");
    chk("pre_ret3", b2.retired, 2'd3);
    b2.instr_vld = 1'b1; b2.instr_dat = 32'h02030102;
    step2();
    b2.instr_vld = 1'b0;
    step2(); step2();
    chk("mid_busy", b2.busy, 1'b1);
    rst2_n = 1'b0;
    #1;
    chk("midrst_we",      b2.wr_en, 1'b0);
    chk("midrst_retired", b2.retired, 2'd0);
    chk("midrst_ready",   b2.instr_rdy, 1'b0);
    chk("midrst_busy",    b2.busy, 1'b0);
    @(negedge clk);
    rst2_n = 1'b1;
    #1;
    chk("midrel_ready", b2.instr_rdy, 1'b1);
    we_cnt = 0;
    repeat (2 + E2 + 2) begin step2(); we_cnt += int'(b2.wr_en); end
    chk("midrel_we_count", we_cnt, 0);
    chk("midrel_retired", b2.retired, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
